// File: rtl/gpio_in_cond.sv
// gpio_in_cond: synchronise, debounce and parity-tag 16 GPIO input pins; GPIO_IN_COND_IRQ_EN adds a sticky change flag
module gpio_in_cond #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [15:0] PINS,
   input  logic        PARITYSEL,
   input  logic        IRQCLR,
   output logic [16:0] GPIOIN,
   output logic        STABLE,
   output logic        IRQ
);
   localparam logic IDLE = 1'b0;
   localparam logic SETTLING = 1'b1;
   localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);
   logic [15:0] sync1, sync2, cand, deb;
   logic [7:0] cnt;
   logic state;
   // two-flop synchroniser for the asynchronous pins
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= PINS;
         sync2 <= sync1;
      end
   end
   // any new synchronised value restarts settling; a full stable count accepts it atomically
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         cand  <= '0;
         deb   <= '0;
         cnt   <= '0;
         state <= IDLE;
      end else if (sync2 != cand) begin
         cand  <= sync2;
         cnt   <= '0;
         state <= SETTLING;
      end else if (state == SETTLING) begin
         if (cnt == LAST) begin
            deb   <= cand;
            state <= IDLE;
         end else begin
            cnt <= cnt + 8'd1;
         end
      end
   end
   assign STABLE = (state == IDLE);
   assign GPIOIN = {PARITYSEL ? ~^deb : ^deb, deb};
`ifdef GPIO_IN_COND_IRQ_EN
   logic irq_q;
   logic irq_set;
   assign irq_set = (state == SETTLING) && (sync2 == cand) && (cnt == LAST) && (cand != deb);
   // sticky flag on a real debounced change; set beats a coincident clear
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) irq_q <= 1'b0;
      else irq_q <= irq_set ? 1'b1 : IRQCLR ? 1'b0 : irq_q;
   end
   assign IRQ = irq_q;
`else
   logic unused_irqclr;
   assign unused_irqclr = IRQCLR;
   assign IRQ = 1'b0;
`endif
endmodule

// File: tb/tb_gpio_in_cond.sv
// tb_gpio_in_cond: checks two debounce depths against a run-length model of the pin history
module tb_gpio_in_cond;
   logic HCLK = 1'b0;
   logic HRESETn = 1'b0;
   logic [15:0] PINS = '0;
   logic PARITYSEL = 1'b0;
   logic IRQCLR = 1'b0;
   logic [16:0] gpioin4, gpioin1;
   logic stable4, stable1, irq4, irq1;
   int n_tests = 0;
   int n_fail = 0;
   logic [15:0] d0, d1, cur;
   int run;
   logic [15:0] m_deb [2];
   logic m_irq [2];
   int dc [2];

   always #5 HCLK = ~HCLK;

   gpio_in_cond #(.DEBOUNCE_CYCLES(4)) u4 (.HCLK(HCLK), .HRESETn(HRESETn), .PINS(PINS), .PARITYSEL(PARITYSEL),
      .IRQCLR(IRQCLR), .GPIOIN(gpioin4), .STABLE(stable4), .IRQ(irq4));
   gpio_in_cond #(.DEBOUNCE_CYCLES(1)) u1 (.HCLK(HCLK), .HRESETn(HRESETn), .PINS(PINS), .PARITYSEL(PARITYSEL),
      .IRQCLR(IRQCLR), .GPIOIN(gpioin1), .STABLE(stable1), .IRQ(irq1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [16:0] exp_gpioin(input logic [15:0] v);
      logic p;
      p = 1'b0;
      for (int b = 0; b < 16; b++) p = p ^ v[b];
      return {PARITYSEL ? !p : p, v};
   endfunction

   function automatic logic exp_irq(input int k);
`ifdef GPIO_IN_COND_IRQ_EN
      return m_irq[k];
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      d0 = '0; d1 = '0; cur = '0; run = 1000;
      m_deb[0] = '0; m_deb[1] = '0;
      m_irq[0] = 1'b0; m_irq[1] = 1'b0;
   endtask

   // cur is the pin level seen two edges ago; a run longer than the depth is accepted
   task automatic model_edge();
      run = (d1 == cur) ? ((run < 1000) ? run + 1 : run) : 1;
      cur = d1; d1 = d0; d0 = PINS;
      for (int k = 0; k < 2; k++) begin
         logic set;
         set = (run > dc[k]) && (cur != m_deb[k]);
         if (run > dc[k]) m_deb[k] = cur;
         m_irq[k] = set ? 1'b1 : IRQCLR ? 1'b0 : m_irq[k];
      end
   endtask

   task automatic compare_all();
      check("gpioin_d4", 32'(gpioin4), 32'(exp_gpioin(m_deb[0])));
      check("gpioin_d1", 32'(gpioin1), 32'(exp_gpioin(m_deb[1])));
      check("stable_d4", 32'(stable4), 32'(run > dc[0] || !HRESETn));
      check("stable_d1", 32'(stable1), 32'(run > dc[1] || !HRESETn));
      check("irq_d4", 32'(irq4), 32'(exp_irq(0)));
      check("irq_d1", 32'(irq1), 32'(exp_irq(1)));
   endtask

   task automatic tick(input logic [15:0] p, input logic c);
      PINS = p;
      IRQCLR = c;
      @(posedge HCLK);
      #1 model_edge();
      compare_all();
      @(negedge HCLK);
   endtask

   initial begin
      logic [15:0] p;
      dc[0] = 4; dc[1] = 1;
      model_reset();
      repeat (2) @(negedge HCLK);
      compare_all();
      PARITYSEL = 1'b1;
      #1 compare_all();
      check("reset_gpioin", 32'(gpioin4), 32'h10000);
      PARITYSEL = 1'b0;
      HRESETn = 1'b1;
      @(negedge HCLK);
      for (int i = 1; i <= 8; i++) begin
         tick(16'h00a5, 1'b0);
         if (i == 6) check("step_edge6", 32'(gpioin4[15:0]), 32'h0);
         if (i == 7) check("step_edge7", 32'(gpioin4[15:0]), 32'h00a5);
         if (i == 4) check("step_d1_edge4", 32'(gpioin1[15:0]), 32'h00a5);
      end
      repeat (8) tick(16'h0000, 1'b1);
      repeat (3) tick(16'h0001, 1'b0);
      repeat (10) tick(16'h0000, 1'b0);
      check("glitch_deb", 32'(gpioin4[15:0]), 32'h0);
      repeat (8) tick(16'h0003, 1'b1);
      PARITYSEL = 1'b0;
      #1 compare_all();
      check("parity_even", 32'(gpioin4[16]), 32'h0);
      PARITYSEL = 1'b1;
      #1 compare_all();
      check("parity_odd", 32'(gpioin4[16]), 32'h1);
      PARITYSEL = 1'b0;
      @(negedge HCLK);
      repeat (8) tick(16'h0007, 1'b0);
      check("parity_7", 32'(gpioin4[16]), 32'h1);
      tick(16'h0007, 1'b1);
      repeat (8) tick(16'h0100, 1'b0);
      repeat (6) tick(16'h0300, 1'b0);
      tick(16'h0300, 1'b1);
      check("irq_set_wins_deb", 32'(gpioin4[15:0]), 32'h0300);
      tick(16'h0300, 1'b1);
      check("irq_cleared", 32'(irq4), 32'h0);
      repeat (8) tick(16'h0000, 1'b1);
      repeat (4) tick(16'hffff, 1'b0);
      HRESETn = 1'b0;
      model_reset();
      #1 compare_all();
      repeat (2) @(negedge HCLK);
      compare_all();
      HRESETn = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick(16'hffff, 1'b0);
         if (i == 6) check("rst_edge6", 32'(gpioin4[15:0]), 32'h0);
      end
      check("rst_edge7", 32'(gpioin4[15:0]), 32'hffff);
      p = 16'hffff;
      repeat (150) begin
         if ($urandom_range(3) != 0) p = 16'($urandom);
         PARITYSEL = 1'($urandom);
         repeat ($urandom_range(1, 7)) tick(p, ($urandom_range(3) == 0));
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/gpio_in_cond.md
GPIO_IN_COND -- requirements
Module: gpio_in_cond

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable synchronised cycles required before a new pin value is accepted; legal range 1..255.
REQ-002 SHALL provide port HCLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port HRESETn  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port PINS  input  16  raw, asynchronous external pin levels.
REQ-005 SHALL provide port PARITYSEL  input  1  1 = odd parity, 0 = even parity.
REQ-006 SHALL provide port IRQCLR  input  1  clears the sticky change flag.
REQ-007 SHALL provide port GPIOIN  output  17  bits [15:0] = debounced value, bit [16] = parity bit; connects directly to the GPIO peripheral's GPIOIN.
REQ-008 SHALL provide port STABLE  output  1  high when no pin change is pending.
REQ-009 SHALL provide port IRQ  output  1  sticky debounced-change flag.

Function
REQ-010 SHALL pass PINS through a two-flop synchroniser; the second stage is the synchronised value SYNC.
REQ-011 SHALL hold a candidate register CAND[15:0], a debounced register DEB[15:0] and a counter CNT of 8 bits.
REQ-012 SHALL implement a two-state FSM: IDLE (DEB == CAND, STABLE = 1) and SETTLING (STABLE = 0).
REQ-013 From either state, if SYNC != CAND: CAND <= SYNC, CNT <= 0, next state SETTLING; DEB is unchanged.
REQ-014 In SETTLING with SYNC == CAND and CNT < DEBOUNCE_CYCLES-1: CNT <= CNT+1.
REQ-015 In SETTLING with SYNC == CAND and CNT == DEBOUNCE_CYCLES-1: DEB <= CAND, next state IDLE.
REQ-016 In IDLE with SYNC == CAND: no register changes.
REQ-017 A clean PINS step SHALL appear on GPIOIN[15:0] after exactly DEBOUNCE_CYCLES+3 rising edges: sync stage 1, sync stage 2, CAND load, then DEBOUNCE_CYCLES count edges.
REQ-018 A SYNC change during SETTLING SHALL restart the count from 0 with the new CAND; there is no partial-bit acceptance.
REQ-019 GPIOIN[16] SHALL be combinational: PARITYSEL ? ~^DEB : ^DEB, so a PARITYSEL change is reflected in the same cycle.
REQ-020 Any multi-bit change SHALL be accepted atomically; all 16 bits update on the same edge.

Reset
REQ-021 On HRESETn low, the synchroniser, CAND, DEB and CNT SHALL be 0, the FSM SHALL be IDLE and IRQ SHALL be 0, asynchronously.
REQ-022 At reset, GPIOIN SHALL equal {PARITYSEL, 16'h0000} and STABLE SHALL be 1.
REQ-023 Reset asserted mid-SETTLING SHALL discard the pending candidate; after release, the first SYNC difference from 0 SHALL start a fresh count.

Configuration
REQ-024 Macro GPIO_IN_COND_IRQ_EN SHALL control the change flag.
REQ-025 With GPIO_IN_COND_IRQ_EN defined, IRQ SHALL be set on the edge where DEB is loaded with a value different from its previous value.
REQ-026 With GPIO_IN_COND_IRQ_EN defined, IRQ SHALL be cleared on an edge with IRQCLR = 1; when set and clear coincide, set wins.
REQ-027 With GPIO_IN_COND_IRQ_EN defined, a DEB load with an identical value (glitch returning to the old level) SHALL NOT set IRQ.
REQ-028 Without GPIO_IN_COND_IRQ_EN, IRQ SHALL be constant 0, IRQCLR SHALL be ignored and no flag register SHALL exist.

Verification
REQ-029 Step: DEBOUNCE_CYCLES = 4, PINS 0000 -> 00A5 held -> GPIOIN[15:0] = 00A5 after exactly 7 edges; STABLE low for edges 3..6.
REQ-030 Glitch: PINS 0000 -> 0001 for 3 cycles -> 0000 -> GPIOIN stays 00000; IRQ stays 0 (IRQ_EN defined).
REQ-031 Parity: DEB = 0003, PARITYSEL toggles 0 -> 1 -> GPIOIN[16] goes 0 -> 1 in the same cycle; DEB = 0007 with PARITYSEL = 0 -> GPIOIN[16] = 1.
REQ-032 IRQ: accepted change to 0100, then IRQCLR pulsed on the same edge as the next accepted change to 0300 -> IRQ remains 1; an IRQCLR pulse alone -> IRQ = 0.
REQ-033 Reset mid-SETTLING: PINS 0000 -> FFFF, HRESETn low at edge 5 for 2 cycles -> GPIOIN = {PARITYSEL, 0000}; after release with PINS held at FFFF -> FFFF accepted 7 edges after release.
REQ-034 DEBOUNCE_CYCLES = 1, build without GPIO_IN_COND_IRQ_EN, PINS 0000 -> 1234 -> GPIOIN[15:0] = 1234 after 4 edges; IRQ constantly 0.
